// File: rtl/regdst_sel_pipe.sv
// regdst_sel_pipe: buffered writeback destination-register selector with a DEPTH-entry valid/ready FIFO.
// Optional ZERO_REG_SUPPRESS_EN: clear the stored regwrite flag when the selected index is 0.
module regdst_sel_pipe #(
    parameter int WIDTH      = 5,
    parameter int N_ENTRADAS = 4,
    parameter int SEL_W      = 2,
    parameter int DEPTH      = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_ENTRADAS*WIDTH-1:0] entradas,
    input  logic [SEL_W-1:0]            seletor,
    input  logic                        escreve_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            saida,
    output logic                        escreve_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        flush,
    output logic [$clog2(DEPTH):0]      ocupacao,
    output logic                        erro_sel
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_LAST = OCC_W'(DEPTH - 1);

    typedef enum logic [1:0] {VAZIO, PARCIAL, CHEIO} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   ocup_q, ocup_d;
    logic               erro_q, erro_d;
    logic [WIDTH:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]   sel_idx;
    logic               sel_ok, esc_new, push, pop;
    logic [WIDTH:0]     head;

    always_comb begin
        sel_idx = '0;
        sel_ok  = 1'b0;
        for (int i = 0; i < N_ENTRADAS; i++) begin
            if (seletor == SEL_W'(i)) begin
                sel_idx = entradas[i*WIDTH +: WIDTH];
                sel_ok  = 1'b1;
            end
        end
`ifdef ZERO_REG_SUPPRESS_EN
        esc_new = sel_ok & escreve_in & (|sel_idx);
`else
        esc_new = sel_ok & escreve_in;
`endif
    end

    assign in_ready  = (state_q != CHEIO);
    assign out_valid = (state_q != VAZIO);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = flush ? '0 : push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = flush ? '0 : pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        ocup_d   = flush ? '0 : (push && !pop) ? ocup_q + OCC_ONE
                 : (pop && !push) ? ocup_q - OCC_ONE : ocup_q;
        erro_d   = flush ? 1'b0 : erro_q | (push & ~sel_ok);
        state_d  = state_q;
        unique case (state_q)
            VAZIO:   state_d = push ? PARCIAL : VAZIO;
            PARCIAL: state_d = (push && !pop && ocup_q == OCC_LAST) ? CHEIO
                             : (pop && !push && ocup_q == OCC_ONE) ? VAZIO : PARCIAL;
            CHEIO:   state_d = pop ? PARCIAL : CHEIO;
            default: state_d = VAZIO;
        endcase
        if (flush) state_d = VAZIO;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= VAZIO;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ocup_q   <= '0;
            erro_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ocup_q   <= ocup_d;
            erro_q   <= erro_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {esc_new, sel_idx};
    end

    assign head        = mem_q[rd_ptr_q];
    assign saida       = out_valid ? head[WIDTH-1:0] : '0;
    assign escreve_out = out_valid & head[WIDTH];
    assign ocupacao    = ocup_q;
    assign erro_sel    = erro_q;
endmodule

// File: tb/tb_regdst_sel_pipe.sv
// tb_regdst_sel_pipe: directed vector table on a 4-input DUT plus hand sequences on a 3-input DUT.
module tb_regdst_sel_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] a_entr = {5'd31, 5'd12, 5'd7, 5'd3};
    logic [1:0]  a_sel = '0;
    logic        a_esc = 0, a_iv = 0, a_ordy = 0, a_fl = 0;
    logic        a_ir, a_eo, a_ov, a_er;
    logic [4:0]  a_sa;
    logic [1:0]  a_occ;

    logic [14:0] b_entr = {5'd9, 5'd20, 5'd0};
    logic [1:0]  b_sel = '0;
    logic        b_esc = 0, b_iv = 0, b_ordy = 0, b_fl = 0;
    logic        b_ir, b_eo, b_ov, b_er;
    logic [4:0]  b_sa;
    logic [1:0]  b_occ;

    regdst_sel_pipe #(.WIDTH(5), .N_ENTRADAS(4), .SEL_W(2), .DEPTH(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .entradas(a_entr), .seletor(a_sel), .escreve_in(a_esc),
        .in_valid(a_iv), .in_ready(a_ir), .saida(a_sa), .escreve_out(a_eo), .out_valid(a_ov),
        .out_ready(a_ordy), .flush(a_fl), .ocupacao(a_occ), .erro_sel(a_er));

    regdst_sel_pipe #(.WIDTH(5), .N_ENTRADAS(3), .SEL_W(2), .DEPTH(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .entradas(b_entr), .seletor(b_sel), .escreve_in(b_esc),
        .in_valid(b_iv), .in_ready(b_ir), .saida(b_sa), .escreve_out(b_eo), .out_valid(b_ov),
        .out_ready(b_ordy), .flush(b_fl), .ocupacao(b_occ), .erro_sel(b_er));

`ifdef ZERO_REG_SUPPRESS_EN
    localparam logic ZS = 1'b1;
`else
    localparam logic ZS = 1'b0;
`endif

    typedef struct {
        logic       iv;
        logic [1:0] sel;
        logic       esc, ordy, fl;
        logic       ov;
        logic [4:0] sa;
        logic       eo;
        logic [1:0] occ;
        logic       ir;
    } vec_t;

    vec_t tbl [19];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic iv, input logic [1:0] sel, input logic esc,
                           input logic ordy, input logic fl);
        b_iv = iv; b_sel = sel; b_esc = esc; b_ordy = ordy; b_fl = fl;
    endtask

    task automatic chk_b(input string nm, input logic ov, input logic [4:0] sa, input logic eo,
                         input logic [1:0] occ, input logic er);
        chk({nm, " ov"}, 32'(b_ov), 32'(ov));
        chk({nm, " saida"}, 32'(b_sa), 32'(sa));
        chk({nm, " esc"}, 32'(b_eo), 32'(eo));
        chk({nm, " occ"}, 32'(b_occ), 32'(occ));
        chk({nm, " erro"}, 32'(b_er), 32'(er));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7,  1'b1, 2'd1, 1'b1};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 1'b1};
        tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 2'd1, 1'b1};
        tbl[3]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 2'd2, 1'b0};
        tbl[4]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 2'd2, 1'b0};
        tbl[5]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 2'd1, 1'b1};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 1'b1};
        tbl[7]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  1'b1, 2'd1, 1'b1};
        tbl[8]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 2'd1, 1'b1};
        tbl[9]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 1'b1, 2'd1, 1'b1};
        tbl[10] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 1'b1, 2'd1, 1'b1};
        tbl[11] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 2'd1, 1'b1};
        tbl[12] = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7,  1'b1, 2'd1, 1'b1};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 1'b1};
        tbl[14] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 2'd1, 1'b1};
        tbl[15] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 2'd2, 1'b0};
        tbl[16] = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 2'd0, 1'b1};
        tbl[17] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  1'b1, 2'd1, 1'b1};
        tbl[18] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2'd0, 1'b1};

        #3;
        chk("reset ov", 32'(a_ov), 32'd0);
        chk("reset occ", 32'(a_occ), 32'd0);
        chk("reset in_ready", 32'(a_ir), 32'd1);
        chk("reset saida", 32'(a_sa), 32'd0);
        chk("reset esc", 32'(a_eo), 32'd0);
        chk("reset erro", 32'(b_er), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 19; i++) begin
            a_iv = tbl[i].iv; a_sel = tbl[i].sel; a_esc = tbl[i].esc;
            a_ordy = tbl[i].ordy; a_fl = tbl[i].fl;
            step();
            chk($sformatf("r%0d ov", i), 32'(a_ov), 32'(tbl[i].ov));
            chk($sformatf("r%0d saida", i), 32'(a_sa), 32'(tbl[i].sa));
            chk($sformatf("r%0d esc", i), 32'(a_eo), 32'(tbl[i].eo));
            chk($sformatf("r%0d occ", i), 32'(a_occ), 32'(tbl[i].occ));
            chk($sformatf("r%0d in_ready", i), 32'(a_ir), 32'(tbl[i].ir));
        end
        a_iv = 0; a_ordy = 0;
        chk("a erro clear", 32'(a_er), 32'd0);

        drive_b(1'b1, 2'd3, 1'b1, 1'b0, 1'b0); step(); chk_b("b oor push", 1'b1, 5'd0, 1'b0, 2'd1, 1'b1);
        drive_b(1'b1, 2'd1, 1'b1, 1'b1, 1'b0); step(); chk_b("b push pop", 1'b1, 5'd20, 1'b1, 2'd1, 1'b1);
        drive_b(1'b0, 2'd0, 1'b0, 1'b1, 1'b0); step(); chk_b("b drain", 1'b0, 5'd0, 1'b0, 2'd0, 1'b1);
        drive_b(1'b1, 2'd0, 1'b1, 1'b0, 1'b0); step(); chk_b("b zero idx", 1'b1, 5'd0, ~ZS, 2'd1, 1'b1);
        drive_b(1'b1, 2'd2, 1'b1, 1'b0, 1'b0); step(); chk_b("b fill", 1'b1, 5'd0, ~ZS, 2'd2, 1'b1);
        drive_b(1'b1, 2'd3, 1'b1, 1'b0, 1'b1); step(); chk_b("b flush", 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        drive_b(1'b1, 2'd3, 1'b1, 1'b0, 1'b0); step(); chk_b("b oor again", 1'b1, 5'd0, 1'b0, 2'd1, 1'b1);
        drive_b(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        a_iv = 1; a_sel = 2'd2; a_esc = 1; a_ordy = 0; step();
        a_sel = 2'd3; step();
        a_iv = 0;
        chk("pre-reset occ", 32'(a_occ), 32'd2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async rst ov", 32'(a_ov), 32'd0);
        chk("async rst occ", 32'(a_occ), 32'd0);
        chk("async rst in_ready", 32'(a_ir), 32'd1);
        chk("async rst saida", 32'(a_sa), 32'd0);
        chk("async rst b erro", 32'(b_er), 32'd0);
        chk("async rst b occ", 32'(b_occ), 32'd0);
        #2;
        reset_n = 1'b1;
        step();
        a_iv = 1; a_sel = 2'd0; a_esc = 1; step();
        a_iv = 0;
        chk("post-rst occ", 32'(a_occ), 32'd1);
        chk("post-rst saida", 32'(a_sa), 32'd3);
        chk("post-rst esc", 32'(a_eo), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
